sample_mixer: RTL and testbench

SAMPLE_MIXER -- requirements
Module: sample_mixer

---
 rtl/audio_pkg.sv | 14 +
 rtl/sync_fall_detect.sv | 28 ++
 rtl/sample_mixer.sv | 132 +++++++++++++
 tb/tb_sample_mixer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio widths, per-source control record and mixer state encoding.
package audio_pkg;
    localparam int SAMPLE_BITS = 16;
    localparam int VOLUME_BITS = 8;
    localparam int M_BUF_LEN   = 256;

    typedef struct packed {
        logic                          valid;
        logic [VOLUME_BITS-1:0]        vol;
        logic signed [SAMPLE_BITS-1:0] sample;
    } SourceControlReg_t;

    typedef enum logic [1:0] {IDLE, MAC, SAT, WRITE} mix_state_t;
endpackage

// File: rtl/sync_fall_detect.sv
// Two-flop synchroniser for an asynchronous frame clock plus falling-edge detector.
module sync_fall_detect (
    input  logic mclk,
    input  logic rstn,
    input  logic din,
    output logic fall
);
    logic       s1, s2, s3;
    logic [2:0] vld_pipe;

    // vld_pipe marks which stages hold real post-reset samples, so the reset
    // value of 1 never pairs with a low input to fake an edge.
    always_ff @(posedge mclk) begin
        if (!rstn) begin
            s1       <= 1'b1;
            s2       <= 1'b1;
            s3       <= 1'b1;
            vld_pipe <= '0;
        end else begin
            s1       <= din;
            s2       <= s1;
            s3       <= s2;
            vld_pipe <= {vld_pipe[1:0], 1'b1};
        end
    end

    assign fall = vld_pipe[2] & s3 & ~s2;
endmodule

// File: rtl/sample_mixer.sv
// Per-frame volume-scaled mix of NUM_SRC sources into one saturated sample,
// written to the master buffer LAG slots behind the playback index.
module sample_mixer #(
    parameter int NUM_SRC     = 3,
    parameter int SAMPLE_BITS = audio_pkg::SAMPLE_BITS,
    parameter int VOLUME_BITS = audio_pkg::VOLUME_BITS,
    parameter int M_BUF_LEN   = audio_pkg::M_BUF_LEN,
    parameter int LAG         = 1,
    localparam int AW         = $clog2(M_BUF_LEN)
) (
    input  logic                                      mclk,
    input  logic                                      rstn,
    input  logic                                      lrclk,
    input  logic signed [NUM_SRC-1:0][SAMPLE_BITS-1:0] src_sample,
    input  logic [NUM_SRC-1:0]                        src_valid,
    input  logic [NUM_SRC-1:0][VOLUME_BITS-1:0]       src_vol,
    input  logic                                      mute,
    input  logic [AW-1:0]                             play_index,
    input  logic                                      clr_flags,
    output logic                                      wr_en,
    output logic [AW-1:0]                             wr_addr,
    output logic [SAMPLE_BITS-1:0]                    wr_data,
    output logic                                      busy,
    output logic                                      clip,
    output logic                                      overrun
);
    import audio_pkg::*;

    localparam int ACC_W = SAMPLE_BITS + VOLUME_BITS + $clog2(NUM_SRC) + 1;
    localparam int SW    = ACC_W - VOLUME_BITS;
    localparam int PW    = SAMPLE_BITS + VOLUME_BITS + 1;
    localparam int IW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    mix_state_t                        state, state_nxt;
    SourceControlReg_t [NUM_SRC-1:0]   src_q;
    logic                              mute_q;
    logic [AW-1:0]                     idx_q;
    logic [IW-1:0]                     k_q;
    logic signed [ACC_W-1:0]           acc_q;
    logic signed [PW-1:0]              prod;
    logic [SW-1:0]                     shifted;
    logic                              pos_ovf, neg_ovf;
    logic [SAMPLE_BITS-1:0]            sat_val;
    logic                              frame, clip_set, ovr_set;

    sync_fall_detect u_sync (
        .mclk (mclk),
        .rstn (rstn),
        .din  (lrclk),
        .fall (frame)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge mclk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame) state_nxt = MAC;
            MAC:     if (k_q == IW'(NUM_SRC - 1)) state_nxt = SAT;
            SAT:     state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Signed sample times zero-extended (hence non-negative) gain.
    always_comb begin
        prod = '0;
        if (src_q[k_q].valid)
            prod = $signed(src_q[k_q].sample) * $signed({1'b0, src_q[k_q].vol});
    end

    // Dropping the low VOLUME_BITS is the arithmetic right shift; overflow
    // whenever the bits above the output sign bit disagree with it.
    always_comb begin
        shifted = acc_q[ACC_W-1:VOLUME_BITS];
        pos_ovf = !shifted[SW-1] &&  (|shifted[SW-2:SAMPLE_BITS-1]);
        neg_ovf =  shifted[SW-1] && !(&shifted[SW-2:SAMPLE_BITS-1]);
        sat_val = shifted[SAMPLE_BITS-1:0];
        if (pos_ovf) sat_val = {1'b0, {(SAMPLE_BITS-1){1'b1}}};
        if (neg_ovf) sat_val = {1'b1, {(SAMPLE_BITS-1){1'b0}}};
    end

    assign clip_set = (state == SAT) && !mute_q && (pos_ovf || neg_ovf);
    assign ovr_set  = frame && busy;

    always_ff @(posedge mclk) begin
        if (!rstn) begin
            src_q   <= '0;
            mute_q  <= 1'b0;
            idx_q   <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            clip    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            wr_en   <= (state == SAT);
            clip    <= clip_set | (clip & ~clr_flags);
            overrun <= ovr_set  | (overrun & ~clr_flags);
            case (state)
                IDLE: if (frame) begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        src_q[i].sample <= src_sample[i];
                        src_q[i].vol    <= src_vol[i];
                        src_q[i].valid  <= src_valid[i];
                    end
                    mute_q <= mute;
                    idx_q  <= play_index;
                    k_q    <= '0;
                    acc_q  <= '0;
                end
                MAC: begin
                    acc_q <= acc_q + ACC_W'(prod);
                    k_q   <= k_q + IW'(1);
                end
                SAT: begin
                    wr_data <= mute_q ? '0 : sat_val;
                    wr_addr <= idx_q - AW'(LAG);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sample_mixer.sv
// Directed bench for sample_mixer: latency, mixing, saturation, addressing, flags, reset abort.
module tb_sample_mixer;
    logic              mclk = 1'b0;
    logic              rstn;
    logic              lrclk;
    logic [2:0][15:0]  src_sample;
    logic [2:0]        src_valid;
    logic [2:0][7:0]   src_vol;
    logic              mute;
    logic [7:0]        play_index;
    logic              clr_flags;
    logic              wr_en;
    logic [7:0]        wr_addr;
    logic [15:0]       wr_data;
    logic              busy, clip, overrun;

    int errors = 0;
    int checks = 0;

    sample_mixer dut (
        .mclk(mclk), .rstn(rstn), .lrclk(lrclk), .src_sample(src_sample),
        .src_valid(src_valid), .src_vol(src_vol), .mute(mute),
        .play_index(play_index), .clr_flags(clr_flags), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .clip(clip),
        .overrun(overrun)
    );

    always #5 mclk = ~mclk;

    task automatic set_src(input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2,
                           input logic [2:0] v, input logic [7:0] vol, input logic m,
                           input logic [7:0] pi);
        src_sample[0] = s0; src_sample[1] = s1; src_sample[2] = s2;
        src_valid = v;
        src_vol[0] = vol; src_vol[1] = vol; src_vol[2] = vol;
        mute = m;
        play_index = pi;
    endtask

    // Drops lrclk at a negedge and watches 16 cycles; lat is the cycle count
    // (from the drop) of the first wr_en. Inputs are scrambled after the snapshot.
    task automatic run_frame(input bit refall, output int lat, output int pulses,
                             output logic [15:0] data, output logic [7:0] addr,
                             output logic clip_w);
        lat = -1; pulses = 0; data = '0; addr = '0; clip_w = 1'b0;
        @(negedge mclk);
        lrclk = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            @(posedge mclk);
            @(negedge mclk);
            if (wr_en) begin
                pulses++;
                if (lat < 0) begin
                    lat = n; data = wr_data; addr = wr_addr; clip_w = clip;
                end
            end
            if (refall) begin
                if (n == 1) lrclk = 1'b1;
                if (n == 2) lrclk = 1'b0;
                if (n == 5) lrclk = 1'b1;
            end else if (n == 3) lrclk = 1'b1;
            if (n == 3) set_src(16'h1234, 16'h7000, 16'h8000, 3'b111, 8'hff, 1'b1, 8'h55);
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0; lrclk = 1'b1; clr_flags = 1'b0;
        set_src(16'd0, 16'd0, 16'd0, 3'b000, 8'd0, 1'b0, 8'd0);
        repeat (3) @(posedge mclk);
        @(negedge mclk);
        checks++; if (wr_en !== 1'b0)    begin errors++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
        checks++; if (wr_addr !== 8'd0)  begin errors++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
        checks++; if (wr_data !== 16'd0) begin errors++; $display("FAIL reset_wr_data got=%0d exp=0", wr_data); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (clip !== 1'b0)     begin errors++; $display("FAIL reset_clip got=%b exp=0", clip); end
        checks++; if (overrun !== 1'b0)  begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        rstn = 1'b1;
        repeat (4) @(negedge mclk);
    endtask

    task automatic test_basic_mix;
        int lat, pulses; logic [15:0] d; logic [7:0] a; logic c;
        set_src(16'd16384, 16'd16384, 16'd12345, 3'b011, 8'd128, 1'b0, 8'd10);
        run_frame(1'b0, lat, pulses, d, a, c);
        checks++; if (lat !== 7)        begin errors++; $display("FAIL basic_latency got=%0d exp=7", lat); end
        checks++; if (pulses !== 1)     begin errors++; $display("FAIL basic_pulses got=%0d exp=1", pulses); end
        checks++; if (d !== 16'd16384)  begin errors++; $display("FAIL basic_data got=%0d exp=16384", $signed(d)); end
        checks++; if (a !== 8'd9)       begin errors++; $display("FAIL basic_addr got=%0d exp=9", a); end
        checks++; if (c !== 1'b0)       begin errors++; $display("FAIL basic_clip got=%b exp=0", c); end
        checks++; if (wr_data !== 16'd16384 || wr_addr !== 8'd9)
            begin errors++; $display("FAIL basic_hold got=%0d/%0d exp=16384/9", wr_data, wr_addr); end
    endtask

    task automatic test_saturate;
        int lat, pulses; logic [15:0] d; logic [7:0] a; logic c;
        set_src(16'h7fff, 16'h7fff, 16'h7fff, 3'b111, 8'd255, 1'b0, 8'd0);
        run_frame(1'b0, lat, pulses, d, a, c);
        checks++; if (d !== 16'h7fff) begin errors++; $display("FAIL sat_pos_data got=%0d exp=32767", $signed(d)); end
        checks++; if (c !== 1'b1)     begin errors++; $display("FAIL sat_pos_clip got=%b exp=1", c); end
        checks++; if (a !== 8'd255)   begin errors++; $display("FAIL sat_pos_addr got=%0d exp=255", a); end
        @(negedge mclk); clr_flags = 1'b1;
        @(negedge mclk); clr_flags = 1'b0;
        checks++; if (clip !== 1'b0)  begin errors++; $display("FAIL clip_clear got=%b exp=0", clip); end
        set_src(16'h8000, 16'h8000, 16'h8000, 3'b111, 8'd255, 1'b0, 8'd100);
        run_frame(1'b0, lat, pulses, d, a, c);
        checks++; if (d !== 16'h8000) begin errors++; $display("FAIL sat_neg_data got=%0d exp=-32768", $signed(d)); end
        checks++; if (c !== 1'b1)     begin errors++; $display("FAIL sat_neg_clip got=%b exp=1", c); end
        checks++; if (a !== 8'd99)    begin errors++; $display("FAIL sat_neg_addr got=%0d exp=99", a); end
    endtask

    task automatic test_clr_priority;
        int lat, pulses; logic [15:0] d; logic [7:0] a; logic c;
        set_src(16'h7fff, 16'h7fff, 16'h7fff, 3'b111, 8'd255, 1'b0, 8'd1);
        clr_flags = 1'b1;
        run_frame(1'b0, lat, pulses, d, a, c);
        clr_flags = 1'b0;
        checks++; if (c !== 1'b1)    begin errors++; $display("FAIL clr_vs_set got=%b exp=1", c); end
        checks++; if (clip !== 1'b0) begin errors++; $display("FAIL clr_after got=%b exp=0", clip); end
    endtask

    task automatic test_overrun;
        int lat, pulses; logic [15:0] d; logic [7:0] a; logic c;
        set_src(16'd1000, 16'd2000, 16'd3000, 3'b111, 8'd64, 1'b0, 8'd20);
        run_frame(1'b1, lat, pulses, d, a, c);
        checks++; if (pulses !== 1)   begin errors++; $display("FAIL ovr_pulses got=%0d exp=1", pulses); end
        checks++; if (d !== 16'd1500) begin errors++; $display("FAIL ovr_data got=%0d exp=1500", $signed(d)); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
        @(negedge mclk); clr_flags = 1'b1;
        @(negedge mclk); clr_flags = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    endtask

    task automatic test_reset_abort;
        int seen = 0;
        set_src(16'd5000, 16'd5000, 16'd5000, 3'b111, 8'd200, 1'b0, 8'd77);
        @(negedge mclk); clr_flags = 1'b0; lrclk = 1'b0;
        repeat (4) @(negedge mclk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_pre got=%b exp=1", busy); end
        rstn = 1'b0;
        @(negedge mclk);
        checks++; if (wr_en !== 1'b0)    begin errors++; $display("FAIL abort_wr_en got=%b exp=0", wr_en); end
        checks++; if (wr_addr !== 8'd0)  begin errors++; $display("FAIL abort_wr_addr got=%0d exp=0", wr_addr); end
        checks++; if (wr_data !== 16'd0) begin errors++; $display("FAIL abort_wr_data got=%0d exp=0", wr_data); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (clip !== 1'b0 || overrun !== 1'b0)
            begin errors++; $display("FAIL abort_flags got=%b%b exp=00", clip, overrun); end
        rstn = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge mclk);
            if (wr_en || busy) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_frame got=%0d exp=0", seen); end
        lrclk = 1'b1;
        repeat (4) @(negedge mclk);
    endtask

    task automatic test_mute;
        int lat, pulses; logic [15:0] d; logic [7:0] a; logic c;
        set_src(16'h7fff, 16'h7fff, 16'h7fff, 3'b111, 8'd255, 1'b1, 8'd40);
        run_frame(1'b0, lat, pulses, d, a, c);
        checks++; if (lat !== 7)      begin errors++; $display("FAIL mute_latency got=%0d exp=7", lat); end
        checks++; if (d !== 16'd0)    begin errors++; $display("FAIL mute_data got=%0d exp=0", $signed(d)); end
        checks++; if (c !== 1'b0)     begin errors++; $display("FAIL mute_clip got=%b exp=0", c); end
        checks++; if (a !== 8'd39)    begin errors++; $display("FAIL mute_addr got=%0d exp=39", a); end
    endtask

    initial begin
        test_reset();
        test_basic_mix();
        test_saturate();
        test_clr_priority();
        test_overrun();
        test_reset_abort();
        test_mute();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
